// File: rtl/pyramid_scheduler.sv
// pyramid_scheduler: sequences 9 blur and 2 half jobs over a 3-octave, 3-level image pyramid.
// Defining PYRAMID_SCHED_TIMEOUT_EN adds a per-job watchdog that aborts a stalled build.
module pyramid_scheduler #(
    parameter int TOP_WIDTH      = 64,
    parameter int TOP_HEIGHT     = 64,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         start_in,
    output logic                         busy,
    output logic                         pyramid_done,
    output logic                         error_out,
    output logic                         blur_start,
    input  logic                         blur_done,
    output logic                         half_start,
    input  logic                         half_done,
    output logic [3:0]                   src_code,
    output logic [3:0]                   dst_code,
    output logic [$clog2(TOP_WIDTH):0]   job_width,
    output logic [$clog2(TOP_HEIGHT):0]  job_height,
    output logic [1:0]                   octave,
    output logic [1:0]                   level
);
    localparam int WW = $clog2(TOP_WIDTH) + 1;
    localparam int HW = $clog2(TOP_HEIGHT) + 1;
    typedef enum logic [2:0] {IDLE, BLUR_ISSUE, BLUR_WAIT, HALF_ISSUE, HALF_WAIT, FINISH} state_t;
    state_t state_q, state_d;
    logic [1:0] oct_q, oct_d, lvl_q, lvl_d;
    logic timeout, waiting, wait_done, half_job;
    logic [3:0] base;
    assign waiting   = state_q == BLUR_WAIT || state_q == HALF_WAIT;
    assign wait_done = (state_q == BLUR_WAIT && blur_done) || (state_q == HALF_WAIT && half_done);
`ifdef PYRAMID_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic err_q, err_d;
    // The ISSUE cycle counts as the first elapsed cycle of the job.
    assign cnt_d = (state_q == BLUR_ISSUE || state_q == HALF_ISSUE) ? CW'(1) :
                   waiting ? cnt_q + CW'(1) : cnt_q;
    assign timeout = waiting && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    assign err_d = (state_q == IDLE && start_in) ? 1'b0 : (timeout && !wait_done) ? 1'b1 : err_q;
    assign error_out = err_q;
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    assign timeout   = 1'b0;
    assign error_out = 1'b0;
`endif
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            oct_q   <= 2'd0;
            lvl_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            oct_q   <= oct_d;
            lvl_q   <= lvl_d;
        end
    end
    always_comb begin
        state_d = state_q;
        oct_d   = oct_q;
        lvl_d   = lvl_q;
        case (state_q)
            IDLE: if (start_in) begin
                state_d = BLUR_ISSUE;
                oct_d   = 2'd0;
                lvl_d   = 2'd0;
            end
            BLUR_ISSUE: state_d = BLUR_WAIT;
            HALF_ISSUE: state_d = HALF_WAIT;
            BLUR_WAIT: if (blur_done) begin
                if (lvl_q < 2'd2) begin
                    lvl_d   = lvl_q + 2'd1;
                    state_d = BLUR_ISSUE;
                end else state_d = (oct_q < 2'd2) ? HALF_ISSUE : FINISH;
            end else if (timeout) state_d = FINISH;
            HALF_WAIT: if (half_done) begin
                oct_d   = oct_q + 2'd1;
                lvl_d   = 2'd0;
                state_d = BLUR_ISSUE;
            end else if (timeout) state_d = FINISH;
            FINISH: begin
                state_d = IDLE;
                oct_d   = 2'd0;
                lvl_d   = 2'd0;
            end
            default: state_d = IDLE;
        endcase
    end
    assign half_job     = state_q == HALF_ISSUE || state_q == HALF_WAIT;
    assign busy         = state_q != IDLE;
    assign pyramid_done = state_q == FINISH;
    assign blur_start   = state_q == BLUR_ISSUE;
    assign half_start   = state_q == HALF_ISSUE;
    // Pyramid image (o, l) is coded o*3+l+1; resize buffers for octaves 1/2 are 10/11.
    assign base       = 4'(oct_q) * 4'd3;
    assign src_code   = (state_q == IDLE) ? 4'd0 : half_job ? base + 4'd3 :
                        (lvl_q != 2'd0) ? base + 4'(lvl_q) :
                        (oct_q == 2'd0) ? 4'd0 : 4'd9 + 4'(oct_q);
    assign dst_code   = (state_q == IDLE) ? 4'd0 : half_job ? 4'd10 + 4'(oct_q) :
                        base + 4'(lvl_q) + 4'd1;
    assign job_width  = WW'(TOP_WIDTH) >> oct_q;
    assign job_height = HW'(TOP_HEIGHT) >> oct_q;
    assign octave     = oct_q;
    assign level      = lvl_q;
endmodule

// File: tb/tb_pyramid_scheduler.sv
// tb_pyramid_scheduler: randomized-latency builds checked against a job list derived from the pyramid rules.
module tb_pyramid_scheduler;
    localparam int TW = 64, TH = 64;
`ifdef PYRAMID_SCHED_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 65536;
`endif
    logic clk_in = 1'b0, rst_in = 1'b1, start_in = 1'b0, blur_done = 1'b0, half_done = 1'b0;
    logic busy, pyramid_done, error_out, blur_start, half_start;
    logic [3:0] src_code, dst_code;
    logic [6:0] job_width, job_height;
    logic [1:0] octave, level;
    int tests = 0, fails = 0;
    typedef struct {bit half; int src; int dst; int oct; int lvl;} job_t;
    job_t jobs[$];

    always #5 clk_in = ~clk_in;

    pyramid_scheduler #(.TOP_WIDTH(TW), .TOP_HEIGHT(TH), .TIMEOUT_CYCLES(TO)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .busy(busy),
        .pyramid_done(pyramid_done), .error_out(error_out), .blur_start(blur_start),
        .blur_done(blur_done), .half_start(half_start), .half_done(half_done),
        .src_code(src_code), .dst_code(dst_code), .job_width(job_width),
        .job_height(job_height), .octave(octave), .level(level)
    );

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pdone"}, pyramid_done, 0);
        chk({tag, "_err"}, error_out, 0);
        chk({tag, "_bstart"}, blur_start, 0);
        chk({tag, "_hstart"}, half_start, 0);
        chk({tag, "_src"}, src_code, 0);
        chk({tag, "_dst"}, dst_code, 0);
        chk({tag, "_oct"}, octave, 0);
        chk({tag, "_lvl"}, level, 0);
        chk({tag, "_w"}, job_width, TW);
        chk({tag, "_h"}, job_height, TH);
    endtask

    task automatic check_job(input job_t e, input bit issuing);
        chk("blur_start", blur_start, 32'(issuing && !e.half));
        chk("half_start", half_start, 32'(issuing && e.half));
        chk("src", src_code, e.src);
        chk("dst", dst_code, e.dst);
        chk("octave", octave, e.oct);
        chk("level", level, e.lvl);
        chk("width", job_width, TW >> e.oct);
        chk("height", job_height, TH >> e.oct);
        chk("busy", busy, 1);
        chk("pdone_early", pyramid_done, 0);
    endtask

    task automatic run_build(input int abort_at);
        start_in = 1'b1;
        tick;
        start_in = 1'b0;
        foreach (jobs[j]) begin
            job_t e = jobs[j];
            int lat = $urandom_range(1, 4);
            check_job(e, 1'b1);
            // A done coincident with the start pulse must be ignored.
            if (e.half) half_done = 1'($urandom_range(0, 1));
            else blur_done = 1'($urandom_range(0, 1));
            tick;
            blur_done = 1'b0;
            half_done = 1'b0;
            if (j == abort_at) begin
                rst_in = 1'b1; start_in = 1'b1; blur_done = 1'b1; half_done = 1'b1;
                tick;
                rst_in = 1'b0; start_in = 1'b0; blur_done = 1'b0; half_done = 1'b0;
                return;
            end
            for (int c = 1; c <= lat; c++) begin
                check_job(e, 1'b0);
                start_in = 1'($urandom_range(0, 1));
                if (e.half) blur_done = 1'($urandom_range(0, 1));
                else half_done = 1'($urandom_range(0, 1));
                if (c == lat) begin
                    if (e.half) half_done = 1'b1;
                    else blur_done = 1'b1;
                end
                tick;
                start_in = 1'b0; blur_done = 1'b0; half_done = 1'b0;
            end
        end
        chk("pdone", pyramid_done, 1);
        tick;
        chk("pdone_off", pyramid_done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        for (int o = 0; o < 3; o++) begin
            for (int l = 0; l < 3; l++)
                jobs.push_back('{0, (l == 0) ? ((o == 0) ? 0 : 9 + o) : o * 3 + l, o * 3 + l + 1, o, l});
            if (o < 2) jobs.push_back('{1, o * 3 + 3, 10 + o, o, 2});
        end
        tick;
        tick;
        rst_in = 1'b0;
        chk_reset("reset");
        blur_done = 1'b1; half_done = 1'b1;
        tick;
        blur_done = 1'b0; half_done = 1'b0;
        chk_reset("idle_spurious");
        run_build(-1);
        run_build(3);
        chk_reset("mid_reset");
        tick;
        chk("post_reset_idle", busy, 0);
        run_build(-1);
        chk("no_error", error_out, 0);
`ifdef PYRAMID_SCHED_TIMEOUT_EN
        start_in = 1'b1;
        tick;
        start_in = 1'b0;
        chk("wd_bstart", blur_start, 1);
        for (int c = 1; c < TO; c++) begin
            tick;
            chk("wd_pdone_early", pyramid_done, 0);
            chk("wd_err_early", error_out, 0);
        end
        tick;
        chk("wd_pdone", pyramid_done, 1);
        chk("wd_err", error_out, 1);
        tick;
        chk("wd_idle", busy, 0);
        chk("wd_err_sticky", error_out, 1);
        start_in = 1'b1;
        tick;
        start_in = 1'b0;
        chk("wd_err_clear", error_out, 0);
        chk("wd_restart", blur_start, 1);
        rst_in = 1'b1;
        tick;
        rst_in = 1'b0;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
